bin16_to_bcd6_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double dabble) feeding the six

---
 rtl/bcd_pkg.sv | 45 ++++
 rtl/bcd_add3_nibble.sv | 14 +
 rtl/bin16_to_bcd6_seq.sv | 98 +++++++++
 tb/tb_bin16_to_bcd6_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the HEX display path: BCD nibble width, converter
// FSM encodings and the seven-segment codes used by the digit decoder.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b100_0000;
    localparam logic [6:0] SEG_1     = 7'b111_1001;
    localparam logic [6:0] SEG_2     = 7'b010_0100;
    localparam logic [6:0] SEG_3     = 7'b011_0000;
    localparam logic [6:0] SEG_4     = 7'b001_1001;
    localparam logic [6:0] SEG_5     = 7'b001_0010;
    localparam logic [6:0] SEG_6     = 7'b000_0010;
    localparam logic [6:0] SEG_7     = 7'b111_1000;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b001_0000;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    function automatic logic [6:0] seg_of(input logic [BCD_W-1:0] digit, input logic blank);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
        return seg;
    endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction for one BCD digit: add 3 when the nibble is 5 or more.
module bcd_add3_nibble
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] nibble,
    output logic [BCD_W-1:0] adjusted
);

    always_comb begin
        adjusted = nibble;
        if (nibble >= 4'd5) adjusted = nibble + 4'd3;
    end

endmodule

// File: rtl/bin16_to_bcd6_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock, with a
// valid/ready input, a completion pulse and a leading-zero blank mask.
module bin16_to_bcd6_seq
    import bcd_pkg::*;
#(
    parameter int unsigned IN_WIDTH      = 16,
    parameter int unsigned DIGITS        = 6,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_WIDTH-1:0]       in_bin,
    output logic                      out_valid,
    output logic [BCD_W*DIGITS-1:0]   out_bcd,
    output logic [DIGITS-1:0]         out_blank
);

    localparam int unsigned CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam longint unsigned MAX_IN    = (64'd1 << IN_WIDTH) - 64'd1;
    localparam longint unsigned DEC_RANGE = 64'd10 ** DIGITS;

    if (DEC_RANGE <= MAX_IN) begin : g_range_err
        $error("bin16_to_bcd6_seq: DIGITS too small for IN_WIDTH");
    end

    logic [1:0]                state;
    logic [CNT_W-1:0]          count;
    logic [IN_WIDTH-1:0]       bin_q;
    logic [IN_WIDTH-1:0]       bin_next;
    logic [BCD_W*DIGITS-1:0]   bcd_q;
    logic [BCD_W*DIGITS-1:0]   bcd_adj;
    logic [BCD_W*DIGITS-1:0]   bcd_next;
    logic [DIGITS-1:0]         blank_next;
    logic                      last_iter;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_nibble u_add3 (
            .nibble   (bcd_q[g*BCD_W +: BCD_W]),
            .adjusted (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    assign {bcd_next, bin_next} = {bcd_adj, bin_q} << 1;
    assign last_iter = (count == CNT_W'(IN_WIDTH - 1));
    assign in_ready  = (state != SHIFT);

    // Walk from the top digit down; a digit is blank while every digit above it is zero.
    always_comb begin
        logic zero_run;
        blank_next = '0;
        zero_run   = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            zero_run = zero_run && (bcd_next[(DIGITS-1-i)*BCD_W +: BCD_W] == '0);
            if (BLANK_LEADING != 0 && i != DIGITS - 1) blank_next[DIGITS-1-i] = zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_blank <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (in_valid) begin
                        bin_q <= in_bin;
                        bcd_q <= '0;
                        count <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_next;
                    bin_q <= bin_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_bcd   <= bcd_next;
                        out_blank <= blank_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin16_to_bcd6_seq.sv
// Self-checking bench for bin16_to_bcd6_seq against a decimal-arithmetic reference.
module tb_bin16_to_bcd6_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bin;
    logic        out_valid;
    logic [23:0] out_bcd;
    logic [5:0]  out_blank;

    int checks = 0;
    int errors = 0;
    logic [23:0] hold_bcd;
    logic [5:0]  hold_blank;

    bin16_to_bcd6_seq #(.IN_WIDTH(16), .DIGITS(6), .BLANK_LEADING(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_blank (out_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int k = 0; k < 6; k++) begin
            r[k*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digits k..5 are all zero exactly when v < 10^k.
    function automatic logic [5:0] ref_blank(input int unsigned v);
        logic [5:0] b;
        int unsigned p;
        b = '0;
        p = 10;
        for (int k = 1; k < 6; k++) begin
            if (v < p) b[k] = 1'b1;
            p = p * 10;
        end
        return b;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 9))
            0:       return 16'd0;
            1:       return 16'hFFFF;
            2:       return 16'($urandom_range(0, 9));
            3:       return 16'($urandom_range(0, 999));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic convert(input logic [15:0] v);
        int lat;
        int low;
        @(negedge clk);
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        check("ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_bin   = v;
        @(negedge clk);
        in_valid = 1'b0;
        in_bin   = ~v;
        lat = -1;
        low = 0;
        for (int n = 0; n < 40; n++) begin
            if (out_valid) begin
                lat = n;
                break;
            end
            if (!in_ready) low++;
            check("conv_hold_bcd", out_bcd, hold_bcd);
            @(negedge clk);
        end
        check("conv_latency", lat, 16);
        check("conv_ready_low", low, 16);
        check("conv_bcd", out_bcd, ref_bcd(v));
        check("conv_blank", out_blank, ref_blank(v));
        hold_bcd   = ref_bcd(v);
        hold_blank = ref_blank(v);
        @(negedge clk);
        check("conv_pulse_width", out_valid, 0);
        check("conv_after_bcd", out_bcd, hold_bcd);
    endtask

    task automatic stream(input int n);
        int accepted = 0;
        int pulses   = 0;
        int since    = 0;
        int low      = 0;
        int budget;
        logic [15:0] q[$];
        logic [15:0] v;
        budget = n * 17 + 60;
        for (int c = 0; c < budget && pulses < n; c++) begin
            @(negedge clk);
            since++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("stream_spurious", 1, 0);
                end else begin
                    v = q.pop_front();
                    hold_bcd   = ref_bcd(v);
                    hold_blank = ref_blank(v);
                    check("stream_bcd", out_bcd, hold_bcd);
                    check("stream_blank", out_blank, hold_blank);
                end
                if (pulses > 0) begin
                    check("stream_gap", since, 17);
                    check("stream_ready_low", low, 16);
                end
                since = 0;
                low   = 0;
                pulses++;
            end else begin
                if (!in_ready) low++;
                check("stream_hold_bcd", out_bcd, hold_bcd);
                check("stream_hold_blank", out_blank, hold_blank);
            end
            if (accepted < n) begin
                in_valid = 1'b1;
                in_bin   = pick();
                if (in_ready) begin
                    q.push_back(in_bin);
                    accepted++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("stream_pulse_count", pulses, n);
    endtask

    task automatic quiet_window(input string tag);
        int pulses = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check(tag, pulses, 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bin   = '0;
        hold_bcd   = '0;
        hold_blank = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_bcd", out_bcd, 24'h0);
        check("rst_blank", out_blank, 6'h0);

        convert(16'd0);
        check("zero_bcd_const", out_bcd, 24'h000000);
        check("zero_blank_const", out_blank, 6'b111110);
        convert(16'd65535);
        check("max_bcd_const", out_bcd, 24'h065535);
        check("max_blank_const", out_blank, 6'b100000);
        convert(16'd12345);
        check("seq1_bcd_const", out_bcd, 24'h012345);
        convert(16'd9);
        check("seq2_bcd_const", out_bcd, 24'h000009);
        check("seq2_blank_const", out_blank, 6'b111110);
        convert(16'd10000);
        check("seq3_bcd_const", out_bcd, 24'h010000);
        check("seq3_blank_const", out_blank, 6'b100000);

        // Reset at SHIFT count 7 discards the conversion.
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = 16'd54321;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_ready_low", in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hold_bcd   = '0;
        hold_blank = '0;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_bcd", out_bcd, 24'h0);
        check("mid_rst_blank", out_blank, 6'h0);
        quiet_window("mid_rst_no_pulse");

        // Reset coincident with an accept must leave the block idle.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_bin   = 16'd777;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_accept_ready", in_ready, 1);
        quiet_window("rst_accept_no_pulse");

        stream(6);
        stream(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
